// File: rtl/bcd_updown_counter_ndigit.sv
// bcd_updown_counter_ndigit
//   N-digit cascaded up/down counter. Each 4-bit digit counts decimal (0-9)
//   or hex (0-F). Provides count enable, synchronous parallel load, a
//   combinational terminal-count flag and a one-cycle wrap pulse.
//
//   Build option: define BCDCNT_SATURATE_EN to stop at the end of the range
//   instead of wrapping. The wrap port then pulses for every blocked count.
module bcd_updown_counter_ndigit #(
  parameter int DIGITS  = 4,
  parameter bit DEC_DEF = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  dec,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   d,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  // DEC_DEF only records how integrators tie off dec; it is echoed here so a
  // bad DIGITS setting reports the full configuration.
  if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
    $error("bcd_updown_counter_ndigit: DIGITS=%0d out of range 1..8 (DEC_DEF=%0d)",
           DIGITS, DEC_DEF);
  end

  logic [W-1:0] q_cnt;
  logic [W-1:0] q_load;
  logic [W-1:0] q_rst;
  logic         load_bad;
  logic         terminal;

  function automatic logic [3:0] dig_max(input logic dec_i);
    return dec_i ? 4'd9 : 4'd15;
  endfunction

  // A stale digit above 9 in decimal mode counts as 9, so it sits "at max".
  function automatic logic dig_at_end(input logic [3:0] dig, input logic down,
                                      input logic dec_i);
    return down ? (dig == 4'd0) : (dig >= dig_max(dec_i));
  endfunction

  // One modular step of a single digit; stale decimal digits behave as 9.
  function automatic logic [3:0] dig_step(input logic [3:0] dig, input logic down,
                                          input logic dec_i);
    logic [3:0] mx;
    mx = dig_max(dec_i);
    if (!down) return (dig >= mx) ? 4'd0 : dig + 4'd1;
    if (dig == 4'd0) return mx;
    if (dig > mx) return 4'd8;
    return dig - 4'd1;
  endfunction

  // Ripple carry/borrow chain: a digit steps only when every lower digit is at its end.
  always_comb begin
    logic run;
    run   = 1'b1;
    q_cnt = q;
    for (int k = 0; k < DIGITS; k++) begin
      if (run) q_cnt[4*k +: 4] = dig_step(q[4*k +: 4], mode, dec);
      run = run & dig_at_end(q[4*k +: 4], mode, dec);
    end
    terminal = run;
  end

  // Load sanitising: illegal decimal digits are written as 0 and flagged.
  always_comb begin
    q_load   = d;
    load_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dec && (d[4*k +: 4] > 4'd9)) begin
        q_load[4*k +: 4] = 4'd0;
        load_bad         = 1'b1;
      end
    end
  end

  // Reset value follows direction: all zero for up, all max for down.
  always_comb begin
    q_rst = '0;
    for (int k = 0; k < DIGITS; k++) begin
      q_rst[4*k +: 4] = mode ? dig_max(dec) : 4'd0;
    end
  end

  assign tc = en & terminal;

  // Counter state with priority reset > load > count > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= q_rst;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      q        <= q_load;
      wrap     <= 1'b0;
      load_err <= load_bad;
    end else if (en) begin
      load_err <= 1'b0;
`ifdef BCDCNT_SATURATE_EN
      if (terminal) begin
        wrap <= 1'b1;
      end else begin
        q    <= q_cnt;
        wrap <= 1'b0;
      end
`else
      q    <= q_cnt;
      wrap <= terminal;
`endif
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_ndigit.sv
// Testbench for bcd_updown_counter_ndigit (DIGITS=2, wrap-around build).
// A driver applies inputs on the falling edge and pushes the predicted
// response into a queue; a monitor pops and compares after each rising edge.
module tb_bcd_updown_counter_ndigit;

  localparam int ND = 2;
  localparam int W  = 4 * ND;

  logic         clk;
  logic         reset;
  logic         en;
  logic         mode;
  logic         dec;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         load_err;

  bcd_updown_counter_ndigit #(.DIGITS(ND), .DEC_DEF(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dec      (dec),
    .load     (load),
    .d        (d),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_dig[ND];   // reference model: one integer per decimal/hex digit

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [W-1:0] model_q();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < ND; k++) v[4*k +: 4] = 4'(m_dig[k]);
    return v;
  endfunction

  // Apply one cycle of inputs and predict the DUT response to that edge.
  task automatic drive(input logic r, input logic l, input logic e, input logic mo,
                       input logic de, input logic [W-1:0] dd);
    exp_t x;
    int   mx;
    bit   at_end;
    bit   c;
    @(negedge clk);
    reset = r; load = l; en = e; mode = mo; dec = de; d = dd;
    mx = de ? 9 : 15;
    at_end = 1'b1;
    for (int k = 0; k < ND; k++)
      if (mo ? (m_dig[k] != 0) : (m_dig[k] < mx)) at_end = 1'b0;
    x.tc = e && at_end;
    x.wrap = 1'b0;
    x.err  = 1'b0;
    if (r) begin
      for (int k = 0; k < ND; k++) m_dig[k] = mo ? mx : 0;
    end else if (l) begin
      for (int k = 0; k < ND; k++) begin
        m_dig[k] = int'(dd[4*k +: 4]);
        if (de && m_dig[k] > 9) begin
          m_dig[k] = 0;
          x.err    = 1'b1;
        end
      end
    end else if (e) begin
      c = 1'b1;
      for (int k = 0; k < ND && c; k++) begin
        if (!mo) begin
          if (m_dig[k] >= mx) m_dig[k] = 0;
          else begin m_dig[k]++; c = 1'b0; end
        end else begin
          if (m_dig[k] == 0) m_dig[k] = mx;
          else if (m_dig[k] > mx) begin m_dig[k] = 8; c = 1'b0; end
          else begin m_dig[k]--; c = 1'b0; end
        end
      end
      x.wrap = c;
    end
    x.q = model_q();
    exp_q.push_back(x);
  endtask

  // Monitor: tc is sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic tc_seen;
    exp_t x;
    forever begin
      @(negedge clk);
      #2 tc_seen = tc;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("tc",       32'(tc_seen),  32'(x.tc));
        chk("q",        32'(q),        32'(x.q));
        chk("wrap",     32'(wrap),     32'(x.wrap));
        chk("load_err", 32'(load_err), 32'(x.err));
      end
    end
  end

  initial begin
    logic [W-1:0] rd;
    reset = 1'b1; load = 1'b0; en = 1'b0; mode = 1'b0; dec = 1'b1; d = '0;
    for (int k = 0; k < ND; k++) m_dig[k] = 0;

    // Decimal up: 00..99, terminal at 99, wrap to 00.
    drive(1, 0, 0, 0, 1, '0);
    for (int i = 0; i < 101; i++) drive(0, 0, 1, 0, 1, '0);
    drive(0, 0, 0, 0, 1, '0);

    // Decimal down with borrow and wrap.
    drive(1, 0, 0, 1, 1, '0);
    drive(0, 0, 1, 1, 1, '0);
    drive(0, 1, 0, 1, 1, 8'h10);
    drive(0, 0, 1, 1, 1, '0);
    drive(0, 1, 0, 1, 1, 8'h00);
    drive(0, 0, 1, 1, 1, '0);
    drive(0, 0, 0, 1, 1, '0);

    // Hex up across FF.
    drive(0, 1, 0, 0, 0, 8'hFE);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, '0);

    // Illegal decimal load, load beating en.
    drive(0, 1, 0, 0, 1, 8'h3C);
    drive(0, 1, 1, 0, 1, 8'h25);
    drive(0, 0, 0, 0, 1, '0);

    // Reset beating load and en, reset value follows mode.
    drive(0, 1, 0, 0, 1, 8'h47);
    drive(1, 1, 1, 0, 1, 8'h55);
    drive(0, 1, 0, 1, 1, 8'h47);
    drive(1, 1, 1, 1, 1, 8'h55);

    // Stale hex digits counted in decimal mode.
    drive(0, 1, 0, 0, 0, 8'hAB);
    drive(0, 0, 1, 1, 1, '0);
    drive(0, 1, 0, 0, 0, 8'hAB);
    drive(0, 0, 1, 0, 1, '0);
    drive(0, 0, 1, 0, 1, '0);

    // Randomised mix of all controls.
    for (int i = 0; i < 3000; i++) begin
      rd = W'($urandom);
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 60), rd);
    end
    drive(0, 0, 0, 0, 1, '0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
